mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Byte-wide memory copy/fill initiator that drives the single-port data memory (combinational read, clocked write) as its master. On a Start pulse it copies Length bytes from SrcAddr to DstAddr, or fills Length bytes at DstAddr with a constant. It also keeps a running 8-bit checksum of the bytes written. It sits beside the core's load/store path and owns the memory port while Busy is high.

## Interface
- AW, 8, memory address width; the memory depth is 2**AW bytes.
- clk  in  1  clock; all state updates on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Mode  in  1  selects the operation: 0 = copy, 1 = fill.
- SrcAddr  in  AW  copy source base address; ignored in fill mode.
- DstAddr  in  AW  destination base address.
- Length  in  AW+1  byte count, 0 to 2**AW.
- FillValue  in  8  byte written in fill mode.
- Busy  out  1  high while in READ or WRITE.
- Done  out  1  one-cycle completion pulse.
- Checksum  out  8  sum mod 256 of all bytes written by the last operation.
- MemAddress  out  AW  drives the memory address.
- MemRead  out  1  drives the memory read enable.
- MemWrite  out  1  drives the memory write enable.
- MemWrData  out  8  drives the memory write data.
- MemRdData  in  8  memory read data, combinational from MemAddress.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If Start=1, latch SrcAddr, DstAddr, Length, Mode and FillValue, clear Checksum, and clear the byte counter.
  - If Length=0, go to DONE.
  - Otherwise, copy mode goes to READ and fill mode goes to WRITE.
- READ (copy mode only):
  - MemAddress=src pointer, MemRead=1.
  - At the clock edge, capture MemRdData into the hold register, then go to WRITE.
- WRITE:
  - MemAddress=dst pointer, MemWrite=1.
  - MemWrData = hold register in copy mode, FillValue in fill mode.
  - At the clock edge: add MemWrData to Checksum, increment both pointers (mod 2**AW), and increment the counter.
  - When counter+1 == Length, go to DONE.
  - Otherwise, copy mode goes to READ and fill mode stays in WRITE.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
- Start is ignored in READ, WRITE and DONE; no queuing.
- Address wrap: the pointers roll over from 2**AW-1 to 0 silently.
- Overlap: the copy is strictly forward, byte by byte, in ascending address order. If DstAddr is in (SrcAddr, SrcAddr+Length), already-written bytes are re-read. This is defined behaviour, not an error.
- Length = 2**AW: the whole memory is transferred, with exactly 2**AW writes.
- Inputs are sampled only when Start is accepted; later changes have no effect until the next operation.
- Output defaults:
  - MemRead=0 and MemWrite=0 outside READ and WRITE respectively.
  - MemAddress=0 and MemWrData=0 in IDLE and DONE.
  - MemRead and MemWrite are never high in the same cycle.

## Timing
- Start is sampled at edge E0.
- Copy of N bytes: READ/WRITE alternate for cycles E0 to E2N; Done is high in the cycle after E2N, so 2N+1 cycles from E0 to the end of Done.
- Fill of N bytes: N WRITE cycles; Done is high after EN.
- Length=0: Done is high in the cycle after E0, with no memory strobes.
- Checksum is valid and stable from the Done cycle until the next accepted Start.
- Reset (ResetN=0, any time):
  - Immediately forces IDLE, Busy=0, Done=0, Checksum=0, all Mem* outputs 0.
  - Counters and pointers are cleared.
  - Bytes already written stay in memory. An in-flight write that has not reached its clock edge does not occur.
- Back-to-back: Start may be reasserted in the IDLE cycle that follows Done.

## Structure
- Package mem_copy_pkg: state enum (IDLE, READ, WRITE, DONE), mode constants MODE_COPY=0 and MODE_FILL=1.
- Single flat module, no sub-modules.
- The bench instantiates the existing data memory alongside the engine as the responder.

## Test plan
- Copy, no overlap:
  - Stimulus: preload M[0x10..0x13]=0x11,0x22,0x33,0x44; Start with Mode=0, Src=0x10, Dst=0x80, Length=4.
  - Response: M[0x80..0x83] equals the source, Done 8 cycles after the Start edge, Checksum=0xAA.
- Fill with wrap:
  - Stimulus: Mode=1, Dst=0xFE, Length=4, FillValue=0x5A.
  - Response: M[0xFE], M[0xFF], M[0x00] and M[0x01] all equal 0x5A; Done after 4 cycles; Checksum=0x68.
- Overlapping forward copy:
  - Stimulus: M[0x20]=0x07, Src=0x20, Dst=0x21, Length=3.
  - Response: M[0x21..0x23] all equal 0x07.
- Zero length:
  - Stimulus: Length=0.
  - Response: Done one cycle after Start, MemRead and MemWrite never asserted, Checksum=0.
- Start while busy, then reset:
  - Stimulus: pulse Start again mid-copy; then drop ResetN during a WRITE cycle.
  - Response: the second Start has no effect. On reset, outputs go to 0 at once and only the bytes whose write edges completed before reset are modified.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the byte-wide memory copy/fill engine.
// Holds the FSM state encoding and the operation mode codes.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy/fill master for the single-port data memory.
// Copies or fills Length bytes, keeping an 8-bit checksum of every byte written.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          ResetN,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW:0]   Length,
  input  logic [7:0]    FillValue,
  output logic          Busy,
  output logic          Done,
  output logic [7:0]    Checksum,
  output logic [AW-1:0] MemAddress,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [7:0]    MemWrData,
  input  logic [7:0]    MemRdData
);

  state_t        r_state;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_len;
  logic [AW:0]   r_cnt;
  logic          r_mode;
  logic [7:0]    r_fill;
  logic [7:0]    r_hold;
  logic [7:0]    r_sum;

  logic [7:0]    w_wrData;
  logic          w_last;

  assign w_wrData = (r_mode == MODE_FILL) ? r_fill : r_hold;
  // Counter is AW+1 bits wide so a full-memory transfer (Length = 2**AW) terminates.
  assign w_last   = ((r_cnt + (AW+1)'(1)) == r_len);

  assign Busy     = (r_state == READ) || (r_state == WRITE);
  assign Done     = (r_state == DONE);
  assign Checksum = r_sum;

  always_comb begin
    MemAddress = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemWrData  = '0;
    case (r_state)
      READ: begin
        MemAddress = r_src;
        MemRead    = 1'b1;
      end
      WRITE: begin
        MemAddress = r_dst;
        MemWrite   = 1'b1;
        MemWrData  = w_wrData;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_COPY;
      r_fill  <= '0;
      r_hold  <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_src  <= SrcAddr;
            r_dst  <= DstAddr;
            r_len  <= Length;
            r_mode <= Mode;
            r_fill <= FillValue;
            r_sum  <= '0;
            r_cnt  <= '0;
            if (Length == '0)
              r_state <= DONE;
            else if (Mode == MODE_FILL)
              r_state <= WRITE;
            else
              r_state <= READ;
          end
        end
        READ: begin
          r_hold  <= MemRdData;
          r_state <= WRITE;
        end
        WRITE: begin
          r_sum <= r_sum + w_wrData;
          r_src <= r_src + AW'(1);
          r_dst <= r_dst + AW'(1);
          r_cnt <= r_cnt + (AW+1)'(1);
          if (w_last)
            r_state <= DONE;
          else if (r_mode == MODE_FILL)
            r_state <= WRITE;
          else
            r_state <= READ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a combinational-read data memory as responder.
// Expected writes come from a reference memory model and are checked as the engine issues them.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       ResetN;
  logic       Start;
  logic       Mode;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [8:0] Length;
  logic [7:0] FillValue;
  logic       Busy;
  logic       Done;
  logic [7:0] Checksum;
  logic [7:0] MemAddress;
  logic       MemRead;
  logic       MemWrite;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  logic [7:0] mem    [256];
  logic [7:0] refMem [256];
  logic       tbWe;
  logic [7:0] tbAddr;
  logic [7:0] tbData;

  logic [15:0] expQ[$];
  int vectorsApplied = 0;
  int miscompares = 0;
  int rdCount = 0;
  int wrCount = 0;
  logic bothHigh = 1'b0;

  always #5 clk = ~clk;

  mem_copy_engine #(.AW(8)) dut (
    .clk       (clk),
    .ResetN    (ResetN),
    .Start     (Start),
    .Mode      (Mode),
    .SrcAddr   (SrcAddr),
    .DstAddr   (DstAddr),
    .Length    (Length),
    .FillValue (FillValue),
    .Busy      (Busy),
    .Done      (Done),
    .Checksum  (Checksum),
    .MemAddress(MemAddress),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  // Data memory: combinational read, clocked write; the bench port is only used while the engine is idle.
  assign MemRdData = mem[MemAddress];
  always @(posedge clk) begin
    if (tbWe)
      mem[tbAddr] <= tbData;
    else if (MemWrite)
      mem[MemAddress] <= MemWrData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Write monitor pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (MemRead) rdCount++;
    if (MemWrite) wrCount++;
    if (MemRead && MemWrite) bothHigh = 1'b1;
    if (MemWrite) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'(MemAddress), 32'hFFFF);
      end else begin
        logic [15:0] e;
        e = expQ.pop_front();
        checkOutput("wrAddr", 32'(MemAddress), 32'(e[15:8]));
        checkOutput("wrData", 32'(MemWrData), 32'(e[7:0]));
      end
    end
  end

  task automatic preloadByte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tbWe = 1'b1; tbAddr = a; tbData = d;
    @(posedge clk);
    #1 tbWe = 1'b0;
    refMem[a] = d;
  endtask

  task automatic checkImage(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== refMem[i]) bad++;
    checkOutput(tag, 32'(bad), 0);
  endtask

  task automatic applyStimulus(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                               input logic [8:0] len, input logic [7:0] fill, input int midStartAt);
    logic [7:0] sum = 8'h00;
    int expCycles;
    int cycles = 0;
    int rd0, wr0;
    logic found = 1'b0;
    @(negedge clk);
    checkOutput("idleBusy", 32'(Busy), 0);
    checkOutput("idleDone", 32'(Done), 0);
    Start = 1'b1; Mode = mode; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fill;
    for (int i = 0; i < int'(len); i++) begin
      logic [7:0] as, ad, d;
      as = src + 8'(i);
      ad = dst + 8'(i);
      d  = mode ? fill : refMem[as];
      refMem[ad] = d;
      sum = sum + d;
      expQ.push_back({ad, d});
    end
    expCycles = mode ? int'(len) : 2 * int'(len);
    rd0 = rdCount; wr0 = wrCount;
    @(posedge clk);
    #1 Start = 1'b0;
    while (!found && cycles < expCycles + 20) begin
      @(negedge clk);
      if (Done) begin
        found = 1'b1;
      end else begin
        if (cycles == midStartAt) begin
          Start = 1'b1; Mode = ~mode; SrcAddr = src + 8'h33; DstAddr = 8'h00;
          Length = 9'd2; FillValue = 8'hEE;
        end
        @(posedge clk);
        #1 Start = 1'b0;
        cycles++;
      end
    end
    checkOutput("doneSeen", 32'(found), 1);
    checkOutput("doneCycles", 32'(cycles), 32'(expCycles));
    checkOutput("checksum", 32'(Checksum), 32'(sum));
    checkOutput("busyAtDone", 32'(Busy), 0);
    checkOutput("pendingWrites", 32'(expQ.size()), 0);
    checkOutput("readCount", 32'(rdCount - rd0), mode ? 0 : 32'(len));
    checkOutput("writeCount", 32'(wrCount - wr0), 32'(len));
    checkImage("memImage");
    expQ.delete();
  endtask

  initial begin
    ResetN = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
    Length = '0; FillValue = '0; tbWe = 1'b0; tbAddr = '0; tbData = '0;
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", 32'(Busy), 0);
    checkOutput("rstDone", 32'(Done), 0);
    checkOutput("rstChecksum", 32'(Checksum), 0);
    checkOutput("rstMemRead", 32'(MemRead), 0);
    checkOutput("rstMemWrite", 32'(MemWrite), 0);
    checkOutput("rstMemAddress", 32'(MemAddress), 0);
    ResetN = 1'b1;
    for (int i = 0; i < 256; i++) preloadByte(8'(i), 8'h00);

    // Plain copy, no overlap.
    preloadByte(8'h10, 8'h11); preloadByte(8'h11, 8'h22);
    preloadByte(8'h12, 8'h33); preloadByte(8'h13, 8'h44);
    applyStimulus(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, -1);
    checkOutput("copySum", 32'(Checksum), 32'hAA);
    checkOutput("copyM80", 32'(mem[8'h80]), 32'h11);
    checkOutput("copyM83", 32'(mem[8'h83]), 32'h44);

    // Fill wrapping through the top of memory; starts in the IDLE cycle right after Done.
    applyStimulus(1'b1, 8'h77, 8'hFE, 9'd4, 8'h5A, -1);
    checkOutput("fillSum", 32'(Checksum), 32'h68);
    checkOutput("fillMFF", 32'(mem[8'hFF]), 32'h5A);
    checkOutput("fillM00", 32'(mem[8'h00]), 32'h5A);
    checkOutput("fillM01", 32'(mem[8'h01]), 32'h5A);

    // Overlapping forward copy smears the first byte.
    preloadByte(8'h20, 8'h07);
    applyStimulus(1'b0, 8'h20, 8'h21, 9'd3, 8'h00, -1);
    checkOutput("ovlM21", 32'(mem[8'h21]), 32'h07);
    checkOutput("ovlM23", 32'(mem[8'h23]), 32'h07);

    // Zero length.
    applyStimulus(1'b0, 8'h10, 8'h40, 9'd0, 8'h00, -1);
    checkOutput("zeroSum", 32'(Checksum), 0);

    // Second Start with different inputs mid-copy must be ignored.
    preloadByte(8'h40, 8'h01); preloadByte(8'h41, 8'h02);
    preloadByte(8'h42, 8'h03); preloadByte(8'h43, 8'h04);
    applyStimulus(1'b0, 8'h40, 8'h90, 9'd4, 8'h00, 3);
    checkOutput("busyStartSum", 32'(Checksum), 32'h0A);

    // Whole-memory fill.
    applyStimulus(1'b1, 8'h00, 8'h00, 9'd256, 8'h01, -1);

    // Reset during the second WRITE of a copy: only the first byte lands.
    preloadByte(8'h50, 8'hA1); preloadByte(8'h51, 8'hB2);
    preloadByte(8'h52, 8'hC3); preloadByte(8'h53, 8'hD4);
    @(negedge clk);
    Start = 1'b1; Mode = 1'b0; SrcAddr = 8'h50; DstAddr = 8'hA0; Length = 9'd4;
    expQ.push_back({8'hA0, 8'hA1});
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (3) @(posedge clk);
    #2 ResetN = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(Busy), 0);
    checkOutput("midRstDone", 32'(Done), 0);
    checkOutput("midRstChecksum", 32'(Checksum), 0);
    checkOutput("midRstMemWrite", 32'(MemWrite), 0);
    checkOutput("midRstMemAddress", 32'(MemAddress), 0);
    checkOutput("midRstMemWrData", 32'(MemWrData), 0);
    @(posedge clk);
    @(negedge clk);
    ResetN = 1'b1;
    refMem[8'hA0] = 8'hA1;
    checkOutput("rstPending", 32'(expQ.size()), 0);
    checkOutput("rstMA0", 32'(mem[8'hA0]), 32'hA1);
    checkOutput("rstMA1", 32'(mem[8'hA1]), 32'h01);
    checkImage("rstImage");
    expQ.delete();

    // Engine recovers after reset.
    applyStimulus(1'b1, 8'h00, 8'h30, 9'd2, 8'h99, -1);
    checkOutput("postRstSum", 32'(Checksum), 32'h32);

    checkOutput("rdWrExclusive", 32'(bothHigh), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
